// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH multiplier using one
// WIDTH-bit ripple-carry adder. It produces one result every WIDTH+1 cycles.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   start_i     begin a multiply; accepted only when not busy (IDLE or DONE)
//   a_i         multiplicand, latched on the accepting edge
//   b_i         multiplier, latched on the accepting edge
//   busy_o      high while iterating (RUN)
//   done_o      one-cycle pulse when product_o is updated
//   product_o   last completed 2*WIDTH-bit product; held between completions
//
// RippleCarryAdder is the team's shared adder. It is bundled here so this file
// is self-contained.

module RippleCarryAdder #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[WIDTH];
   end

endmodule

module shift_add_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   m_q;
   logic [2*WIDTH-1:0] p_q;
   logic [CntW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] product_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;
   logic [2*WIDTH-1:0] p_shift;

   // Accumulator is the high half of P; add M only when the current multiplier bit is set.
   assign add_b = p_q[0] ? m_q : '0;

   RippleCarryAdder #(
      .WIDTH(WIDTH)
   ) u_adder (
      .a    (p_q[2*WIDTH-1:WIDTH]),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // The carry becomes the new MSB, so the partial product never loses a bit.
   assign p_shift = {add_cout, add_sum, p_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         m_q       <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start_i) begin
                  m_q     <= a_i;
                  p_q     <= {{WIDTH{1'b0}}, b_i};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               p_q   <= p_shift;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  product_q <= p_shift;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               done_q <= 1'b0;
               if (start_i) begin
                  m_q     <= a_i;
                  p_q     <= {{WIDTH{1'b0}}, b_i};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign product_o = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        busy4, done4;
   logic [7:0]  prod4;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] prod8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_add_multiplier #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start4),
      .a_i       (a4),
      .b_i       (b4),
      .busy_o    (busy4),
      .done_o    (done4),
      .product_o (prod4)
   );

   shift_add_multiplier #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start8),
      .a_i       (a8),
      .b_i       (b8),
      .busy_o    (busy8),
      .done_o    (done8),
      .product_o (prod8)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the selected DUT with a single start pulse, checking
   // busy every RUN cycle, done/product after edge E0+w, and done falling afterwards.
   task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
      if (w == 4) begin
         start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0];
      end else begin
         start8 = 1'b1; a8 = a; b8 = b;
      end
      tick();  // E0
      start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      for (int i = 0; i < w; i++) begin
         check("busy_run", (w == 4) ? busy4 : busy8, 1);
         check("done_run", (w == 4) ? done4 : done8, 0);
         tick();
      end
      check("busy_done", (w == 4) ? busy4 : busy8, 0);
      check("done_pulse", (w == 4) ? done4 : done8, 1);
      check("product", (w == 4) ? {8'h00, prod4} : prod8, exp);
      tick();
      check("done_fall", (w == 4) ? done4 : done8, 0);
      check("product_hold", (w == 4) ? {8'h00, prod4} : prod8, exp);
   endtask

   initial begin
      int dcount;
      logic [7:0] ra, rb;

      vecs[0] = '{4'd13, 4'd11, 8'd143};
      vecs[1] = '{4'd15, 4'd15, 8'd225};
      vecs[2] = '{4'd0,  4'd9,  8'd0};
      vecs[3] = '{4'd7,  4'd6,  8'd42};
      vecs[4] = '{4'd1,  4'd15, 8'd15};
      vecs[5] = '{4'd15, 4'd1,  8'd15};
      vecs[6] = '{4'd8,  4'd8,  8'd64};
      vecs[7] = '{4'd10, 4'd0,  8'd0};

      // Reset state
      #2;
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_product", prod4, 0);
      check("rst_product8", prod8, 0);
      tick();
      rst = 1'b0;
      tick();

      foreach (vecs[i]) run_op(4, 8'(vecs[i].a), 8'(vecs[i].b), 16'(vecs[i].p));

      // 13 x 11, then product must hold through 10 idle cycles
      run_op(4, 8'd13, 8'd11, 16'd143);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_hold", prod4, 143);
         check("idle_busy", busy4, 0);
      end

      // start during RUN is ignored
      start4 = 1'b1; a4 = 4'd7; b4 = 4'd6;
      tick();  // E0
      start4 = 1'b0;
      tick();  // E0+1, now in 2nd RUN cycle
      start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
      tick();  // E0+2
      start4 = 1'b0;
      tick();
      tick();  // E0+4
      check("ign_done", done4, 1);
      check("ign_product", prod4, 42);
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done4 || busy4) dcount++;
      end
      check("ign_no_extra", dcount, 0);
      check("ign_hold", prod4, 42);

      // Back-to-back with start held high
      start4 = 1'b1; a4 = 4'd5; b4 = 4'd5;
      tick();  // E0
      for (int i = 0; i < 3; i++) tick();
      tick();  // E0+4
      check("b2b_done1", done4, 1);
      check("b2b_prod1", prod4, 25);
      a4 = 4'd9; b4 = 4'd7;
      tick();  // E0+5 accepts second op
      start4 = 1'b0;
      check("b2b_busy", busy4, 1);
      check("b2b_done_low", done4, 0);
      for (int i = 0; i < 3; i++) tick();
      check("b2b_still_busy", busy4, 1);
      tick();  // E0+9
      check("b2b_done2", done4, 1);
      check("b2b_prod2", prod4, 63);
      tick();
      check("b2b_fall", done4, 0);

      // Asynchronous reset during the 3rd RUN cycle
      start4 = 1'b1; a4 = 4'd12; b4 = 4'd12;
      tick();  // E0
      start4 = 1'b0;
      tick();
      tick();
      #3 rst = 1'b1;
      #1;
      check("arst_busy", busy4, 0);
      check("arst_done", done4, 0);
      check("arst_product", prod4, 0);
      tick();
      #3 rst = 1'b0;
      tick();
      check("arst_idle_done", done4, 0);
      check("arst_idle_product", prod4, 0);
      run_op(4, 8'd2, 8'd3, 16'd6);

      // WIDTH=8 corner and random pairs
      run_op(8, 8'd255, 8'd255, 16'hFE01);
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op(8, ra, rb, 16'(ra) * 16'(rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
